// File: rtl/dds_freq_ctrl.sv
// dds_freq_ctrl
//   Parses ASCII decimal frequency commands (Hz) from the UART receiver.
//   Each command becomes a 32-bit DDS tuning word,
//   fre_word = floor(freq * 2^32 / CLK_HZ).
//   A sequential restoring divider produces one quotient bit per cycle.
//
// Ports
//   clk            system clock, all logic on posedge
//   rst            synchronous active-high reset
//   rx_data        byte from uart_rx
//   rx_data_valid  byte strobe; a byte is consumed when valid && ready
//   rx_data_ready  high while a new byte can be parsed (IDLE/ERR)
//   fre_word       tuning word to the phase accumulator
//   fre_word_valid one-cycle pulse in the cycle fre_word changes
//   busy           high while a division/commit is in progress
//   err            one-cycle pulse when a command is rejected
//   led            toggles on every committed command
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | collecting digits; a terminator starts the conversion
// S_ERR  | command rejected; drop bytes up to the next terminator
// S_DIV  | restoring division, DIV_W iterations, MSB first
// S_DONE | commit quotient to fre_word, pulse valid, toggle led
module dds_freq_ctrl #(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned FREQ_W       = 24,
  parameter int unsigned FREQ_MAX     = 10_000_000,
  parameter int unsigned MAX_DIGITS   = 8,
  parameter logic [31:0] DEFAULT_WORD = 32'd3564822
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_data_valid,
  output logic        rx_data_ready,
  output logic [31:0] fre_word,
  output logic        fre_word_valid,
  output logic        busy,
  output logic        err,
  output logic        led
);

  localparam int unsigned DIV_W = FREQ_W + 32;
  localparam int unsigned REM_W = $clog2(CLK_HZ) + 1;
  localparam int unsigned ACC_W = FREQ_W + 4;
  localparam int unsigned CNT_W = $clog2(MAX_DIGITS + 1);
  localparam int unsigned IT_W  = $clog2(DIV_W);

  localparam logic [ACC_W-1:0] FREQ_MAX_EXT = ACC_W'(FREQ_MAX);
  localparam logic [REM_W-1:0] CLK_HZ_REM   = REM_W'(CLK_HZ);
  localparam logic [CNT_W-1:0] MAX_DIG_CNT  = CNT_W'(MAX_DIGITS);
  localparam logic [IT_W-1:0]  LAST_IT      = IT_W'(DIV_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_ERR, S_DIV, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [FREQ_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DIV_W-1:0]  dvd_q, dvd_d;
  logic [REM_W-1:0]  rem_q, rem_d;
  logic [31:0]       quo_q, quo_d;
  logic [IT_W-1:0]   it_q, it_d;
  logic [31:0]       word_q, word_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic              led_q, led_d;

  logic             byte_take;
  logic             is_digit;
  logic             is_term;
  logic [ACC_W-1:0] acc_next;
  logic [REM_W-1:0] rem_sh;
  logic             rem_ge;

  assign rx_data_ready = (state_q == S_IDLE) || (state_q == S_ERR);
  assign busy          = (state_q == S_DIV)  || (state_q == S_DONE);
  assign fre_word       = word_q;
  assign fre_word_valid = valid_q;
  assign err            = err_q;
  assign led            = led_q;

  assign byte_take = rx_data_valid && rx_data_ready;
  assign is_digit  = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  assign is_term   = (rx_data == 8'h0D) || (rx_data == 8'h0A);
  // Widened so the overflow against FREQ_MAX is visible before truncation.
  assign acc_next  = (ACC_W'(acc_q) * ACC_W'(10)) + ACC_W'(rx_data[3:0]);

  // The remainder stays below CLK_HZ, so one extra bit holds the shifted value.
  assign rem_sh = {rem_q[REM_W-2:0], dvd_q[DIV_W-1]};
  assign rem_ge = (rem_sh >= CLK_HZ_REM);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    it_d    = it_q;
    word_d  = word_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    led_d   = led_q;
    case (state_q)
      S_IDLE: begin
        if (byte_take) begin
          if (is_digit) begin
            if ((cnt_q == MAX_DIG_CNT) || (acc_next > FREQ_MAX_EXT)) begin
              err_d   = 1'b1;
              state_d = S_ERR;
            end else begin
              acc_d = acc_next[FREQ_W-1:0];
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else if (is_term) begin
            // A bare terminator (e.g. LF after CR) is ignored.
            if (cnt_q != '0) begin
              dvd_d   = {acc_q, 32'b0};
              rem_d   = '0;
              quo_d   = '0;
              it_d    = '0;
              state_d = S_DIV;
            end
          end else begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end
        end
      end
      S_ERR: begin
        if (byte_take && is_term) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      S_DIV: begin
        rem_d = rem_ge ? (rem_sh - CLK_HZ_REM) : rem_sh;
        // Quotient is below 2^32 because FREQ_MAX < CLK_HZ; upper bits drop off.
        quo_d = {quo_q[30:0], rem_ge};
        dvd_d = {dvd_q[DIV_W-2:0], 1'b0};
        it_d  = it_q + IT_W'(1);
        if (it_q == LAST_IT) state_d = S_DONE;
      end
      S_DONE: begin
        word_d  = quo_q;
        valid_d = 1'b1;
        led_d   = ~led_q;
        acc_d   = '0;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      dvd_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      it_q    <= '0;
      word_q  <= DEFAULT_WORD;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      it_q    <= it_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      led_q   <= led_d;
    end
  end

endmodule

// File: tb/tb_dds_freq_ctrl.sv
module tb_dds_freq_ctrl;

  localparam longint unsigned CLK_HZ     = 50_000_000;
  localparam longint unsigned FREQ_MAX   = 10_000_000;
  localparam int              MAX_DIGITS = 8;
  localparam logic [31:0]     DEF_WORD   = 32'd3564822;
  localparam int              LATENCY    = 57;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_data_valid;
  logic        rx_data_ready;
  logic [31:0] fre_word;
  logic        fre_word_valid;
  logic        busy;
  logic        err;
  logic        led;

  dds_freq_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .rx_data       (rx_data),
    .rx_data_valid (rx_data_valid),
    .rx_data_ready (rx_data_ready),
    .fre_word      (fre_word),
    .fre_word_valid(fre_word_valid),
    .busy          (busy),
    .err           (err),
    .led           (led)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int valid_seen = 0;
  int err_seen   = 0;
  int last_valid_cyc = 0;
  int accept_cyc = 0;

  logic [31:0] word_model = DEF_WORD;
  logic        led_model  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (fre_word_valid === 1'b1) begin
      valid_seen++;
      last_valid_cyc = cyc;
    end
    if (err === 1'b1) err_seen++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: walk a command byte stream with the parser rules and produce
  // the resulting word, number of commits and number of rejections.
  function automatic void model_run(input byte q[$], inout logic [31:0] w,
                                    output int commits, output int errs);
    longint unsigned acc = 0;
    int  n = 0;
    bit  in_err = 0;
    commits = 0;
    errs = 0;
    foreach (q[i]) begin
      byte b = q[i];
      bit term  = (b == 8'h0D) || (b == 8'h0A);
      bit digit = (b >= 8'h30) && (b <= 8'h39);
      if (in_err) begin
        if (term) begin in_err = 0; acc = 0; n = 0; end
      end else if (digit) begin
        longint unsigned nxt = acc * 10 + longint'(b - 8'h30);
        if (n == MAX_DIGITS || nxt > FREQ_MAX) begin
          errs++;
          in_err = 1;
        end else begin
          acc = nxt;
          n++;
        end
      end else if (term) begin
        if (n > 0) begin
          w = 32'((acc << 32) / CLK_HZ);
          commits++;
          acc = 0;
          n = 0;
        end
      end else begin
        errs++;
        in_err = 1;
      end
    end
  endfunction

  function automatic void str2q(input string s, output byte q[$]);
    q = {};
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
  endfunction

  task automatic send_byte(input byte b);
    int n = 0;
    @(negedge clk);
    while (rx_data_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (rx_data_ready !== 1'b1) begin
      total++; bad++;
      $display("FAIL ready_timeout: rx_data_ready=%b required 1", rx_data_ready);
    end
    rx_data = b;
    rx_data_valid = 1'b1;
    @(posedge clk);
    #1;
    accept_cyc = cyc;
    rx_data_valid = 1'b0;
  endtask

  task automatic send_q(input byte q[$]);
    foreach (q[i]) send_byte(q[i]);
  endtask

  task automatic send_str(input string s);
    byte q[$];
    str2q(s, q);
    send_q(q);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy !== 1'b0 || rx_data_ready !== 1'b1) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) begin
      total++; bad++;
      $display("FAIL idle_timeout: busy=%b required 0", busy);
    end
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx_data = 8'h00;
    rx_data_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++; if (fre_word !== DEF_WORD) begin bad++; $display("FAIL reset_word: got %0d want %0d", fre_word, DEF_WORD); end
    total++; if (led !== 1'b0) begin bad++; $display("FAIL reset_led: got %b want 0", led); end
    total++; if (rx_data_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", rx_data_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (fre_word_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", fre_word_valid); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
  endtask

  task automatic test_1000();
    byte q[$];
    int v0 = valid_seen, e0 = err_seen, commits, errs, cr_cyc;
    str2q("1000\r", q);
    model_run(q, word_model, commits, errs);
    led_model ^= commits[0];
    send_q(q);
    cr_cyc = accept_cyc;
    wait_idle();
    total++; if (fre_word !== word_model) begin bad++; $display("FAIL w1000_word: got %0d want %0d", fre_word, word_model); end
    total++; if (valid_seen - v0 != 1) begin bad++; $display("FAIL w1000_valid: got %0d pulses want 1", valid_seen - v0); end
    total++; if (last_valid_cyc - cr_cyc != LATENCY) begin bad++; $display("FAIL w1000_latency: got %0d want %0d", last_valid_cyc - cr_cyc, LATENCY); end
    total++; if (led !== led_model) begin bad++; $display("FAIL w1000_led: got %b want %b", led, led_model); end
    total++; if (err_seen - e0 != errs) begin bad++; $display("FAIL w1000_err: got %0d want %0d", err_seen - e0, errs); end
  endtask

  task automatic test_crlf();
    byte q[$];
    int v0 = valid_seen, e0 = err_seen, commits, errs;
    str2q("41500\r\n", q);
    model_run(q, word_model, commits, errs);
    led_model ^= commits[0];
    send_q(q);
    wait_idle();
    total++; if (fre_word !== word_model) begin bad++; $display("FAIL crlf_word: got %0d want %0d", fre_word, word_model); end
    total++; if (valid_seen - v0 != 1) begin bad++; $display("FAIL crlf_valid: got %0d pulses want 1", valid_seen - v0); end
    total++; if (err_seen - e0 != 0) begin bad++; $display("FAIL crlf_err: got %0d pulses want 0", err_seen - e0); end
    total++; if (led !== led_model) begin bad++; $display("FAIL crlf_led: got %b want %b", led, led_model); end
  endtask

  task automatic test_overflow();
    byte q[$];
    int v0 = valid_seen, e0 = err_seen, commits, errs;
    logic [31:0] w_before = word_model;
    send_str("1234567");
    @(negedge clk); #1;
    total++; if (err_seen - e0 != 0) begin bad++; $display("FAIL ovf_early_err: got %0d pulses want 0", err_seen - e0); end
    send_str("8");
    @(negedge clk); #1;
    total++; if (err_seen - e0 != 1) begin bad++; $display("FAIL ovf_err_8th: got %0d pulses want 1", err_seen - e0); end
    send_str("\r");
    wait_idle();
    total++; if (valid_seen - v0 != 0) begin bad++; $display("FAIL ovf_valid: got %0d pulses want 0", valid_seen - v0); end
    total++; if (fre_word !== w_before) begin bad++; $display("FAIL ovf_word_hold: got %0d want %0d", fre_word, w_before); end
    str2q("2000\r", q);
    model_run(q, word_model, commits, errs);
    led_model ^= commits[0];
    send_q(q);
    wait_idle();
    total++; if (fre_word !== word_model) begin bad++; $display("FAIL w2000_word: got %0d want %0d", fre_word, word_model); end
  endtask

  task automatic test_illegal();
    byte q[$];
    int v0 = valid_seen, e0 = err_seen, commits, errs;
    logic [31:0] w_before = word_model;
    send_str("12A");
    @(negedge clk); #1;
    total++; if (err_seen - e0 != 1) begin bad++; $display("FAIL ill_err: got %0d pulses want 1", err_seen - e0); end
    send_str("4\r");
    wait_idle();
    total++; if (err_seen - e0 != 1) begin bad++; $display("FAIL ill_err_once: got %0d pulses want 1", err_seen - e0); end
    total++; if (valid_seen - v0 != 0) begin bad++; $display("FAIL ill_valid: got %0d pulses want 0", valid_seen - v0); end
    total++; if (fre_word !== w_before) begin bad++; $display("FAIL ill_word_hold: got %0d want %0d", fre_word, w_before); end
    str2q("0\r", q);
    model_run(q, word_model, commits, errs);
    led_model ^= commits[0];
    send_q(q);
    wait_idle();
    total++; if (fre_word !== word_model) begin bad++; $display("FAIL zero_word: got %0d want %0d", fre_word, word_model); end
    total++; if (valid_seen - v0 != 1) begin bad++; $display("FAIL zero_valid: got %0d pulses want 1", valid_seen - v0); end
  endtask

  task automatic test_reset_mid_div();
    byte q[$];
    int v0 = valid_seen, commits, errs;
    send_str("5000\r");
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    word_model = DEF_WORD;
    led_model = 1'b0;
    repeat (80) @(negedge clk);
    #1;
    total++; if (valid_seen - v0 != 0) begin bad++; $display("FAIL abort_valid: got %0d pulses want 0", valid_seen - v0); end
    total++; if (fre_word !== word_model) begin bad++; $display("FAIL abort_word: got %0d want %0d", fre_word, word_model); end
    total++; if (led !== led_model) begin bad++; $display("FAIL abort_led: got %b want %b", led, led_model); end
    str2q("5000\r", q);
    model_run(q, word_model, commits, errs);
    led_model ^= commits[0];
    send_q(q);
    wait_idle();
    total++; if (fre_word !== word_model) begin bad++; $display("FAIL w5000_word: got %0d want %0d", fre_word, word_model); end
  endtask

  task automatic test_back_to_back();
    byte q[$];
    int v0 = valid_seen, commits, errs;
    str2q("9000\r", q);
    model_run(q, word_model, commits, errs);
    led_model ^= commits[0];
    send_q(q);
    // Bytes offered while the divider is busy must not be consumed.
    @(negedge clk);
    rx_data = 8'h39;
    rx_data_valid = 1'b1;
    repeat (10) @(negedge clk);
    rx_data_valid = 1'b0;
    wait_idle();
    total++; if (fre_word !== word_model) begin bad++; $display("FAIL b2b_first_word: got %0d want %0d", fre_word, word_model); end
    str2q("7\r", q);
    model_run(q, word_model, commits, errs);
    led_model ^= commits[0];
    send_q(q);
    wait_idle();
    total++; if (fre_word !== word_model) begin bad++; $display("FAIL b2b_drop_word: got %0d want %0d", fre_word, word_model); end
    total++; if (valid_seen - v0 != 2) begin bad++; $display("FAIL b2b_valid: got %0d pulses want 2", valid_seen - v0); end
  endtask

  task automatic test_random();
    byte ill[4] = '{8'h41, 8'h20, 8'h2F, 8'h3A};
    for (int it = 0; it < 40; it++) begin
      byte q[$];
      int v0 = valid_seen, e0 = err_seen, commits, errs, nd;
      nd = $urandom_range(1, 9);
      for (int k = 0; k < nd; k++) begin
        if ($urandom_range(0, 11) == 0) q.push_back(ill[$urandom_range(0, 3)]);
        else q.push_back(8'(8'h30 + $urandom_range(0, 9)));
      end
      q.push_back($urandom_range(0, 1) ? 8'h0D : 8'h0A);
      if ($urandom_range(0, 1)) q.push_back(8'h0A);
      model_run(q, word_model, commits, errs);
      led_model ^= commits[0];
      send_q(q);
      wait_idle();
      total++; if (fre_word !== word_model) begin bad++; $display("FAIL rnd_word[%0d]: got %0d want %0d", it, fre_word, word_model); end
      total++; if (valid_seen - v0 != commits) begin bad++; $display("FAIL rnd_valid[%0d]: got %0d want %0d", it, valid_seen - v0, commits); end
      total++; if (err_seen - e0 != errs) begin bad++; $display("FAIL rnd_err[%0d]: got %0d want %0d", it, err_seen - e0, errs); end
    end
    total++; if (led !== led_model) begin bad++; $display("FAIL rnd_led: got %b want %b", led, led_model); end
  endtask

  initial begin
    rst = 1'b1;
    rx_data = 8'h00;
    rx_data_valid = 1'b0;
    test_reset();
    test_1000();
    test_crlf();
    test_overflow();
    test_illegal();
    test_reset_mid_div();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
